// File: rtl/ext_mem_ctrl.sv
// ext_mem_ctrl: byte-wide external memory controller with wait states.
// Ports: clk, rst_n, ext_mem_addr/wdata/read/write/cs in; rdata, rdata_oe, ready, bus_error out.
module ext_mem_ctrl #(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ext_mem_addr,
    input  logic [7:0]  ext_mem_wdata,
    output logic [7:0]  ext_mem_rdata,
    output logic        ext_mem_rdata_oe,
    input  logic        ext_mem_read,
    input  logic        ext_mem_write,
    input  logic        ext_mem_cs,
    output logic        ext_mem_ready,
    output logic        bus_error
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);
    localparam logic [3:0] WS_LAST =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        HOLD
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        rd_q;
    logic        wr_q;
    logic        err_q;

    logic [7:0]  mem [MEM_DEPTH];

    logic        req;
    logic        hold_rel;
    logic        enter_ack;
    logic [15:0] txn_addr;
    logic [7:0]  txn_wdata;
    logic        txn_rd;
    logic        txn_wr;
    logic        txn_err;
    logic [AW-1:0] txn_idx;

    assign req      = ext_mem_cs && (ext_mem_read || ext_mem_write);
    assign hold_rel = !ext_mem_cs || (!ext_mem_read && !ext_mem_write);

    // With zero wait states ACK is entered straight from IDLE, before the
    // latches hold the request, so the live inputs are used there.
    assign txn_addr  = (state == IDLE) ? ext_mem_addr  : addr_q;
    assign txn_wdata = (state == IDLE) ? ext_mem_wdata : wdata_q;
    assign txn_rd    = (state == IDLE) ? ext_mem_read  : rd_q;
    assign txn_wr    = (state == IDLE) ? ext_mem_write : wr_q;
    assign txn_idx   = txn_addr[AW-1:0];
    assign txn_err   = ({16'd0, txn_addr} >= DEPTH_U) || (txn_rd && txn_wr);

    assign enter_ack = (state_nx == ACK);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                cnt_nx = 4'd0;
                if (req) begin
                    if (WAIT_STATES > 0) state_nx = WAIT;
                    else                 state_nx = ACK;
                end
            end
            WAIT: begin
                if (cnt == WS_LAST) begin
                    state_nx = ACK;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            ACK:  state_nx = HOLD;
            HOLD: if (hold_rel) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 16'd0;
            wdata_q <= 8'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == IDLE && req) begin
            addr_q  <= ext_mem_addr;
            wdata_q <= ext_mem_wdata;
            rd_q    <= ext_mem_read;
            wr_q    <= ext_mem_write;
            err_q   <= txn_err;
        end
    end

    // Read data only changes when a read reaches ACK; it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_mem_rdata <= 8'h00;
        end else if (enter_ack && txn_rd) begin
            ext_mem_rdata <= txn_err ? 8'hFF : mem[txn_idx];
        end
    end

    // Storage is deliberately not reset; rst_n only blocks a write that
    // would otherwise coincide with a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && enter_ack && txn_wr && !txn_err) begin
            mem[txn_idx] <= txn_wdata;
        end
    end

    assign ext_mem_ready    = (state == ACK);
    assign bus_error        = (state == ACK) && err_q;
    assign ext_mem_rdata_oe = ((state == ACK) || (state == HOLD)) && rd_q
                              && ext_mem_read && ext_mem_cs;

endmodule

// File: tb/tb_ext_mem_ctrl.sv
// tb_ext_mem_ctrl: directed bench for ext_mem_ctrl, one instance with
// one wait state (dut1) and one with none (dut0), sharing address/data/strobes.
module tb_ext_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rd;
    logic        wr;
    logic        cs1;
    logic        cs0;

    logic [7:0]  rdata1;
    logic        oe1;
    logic        rdy1;
    logic        berr1;
    logic [7:0]  rdata0;
    logic        oe0;
    logic        rdy0;
    logic        berr0;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    ext_mem_ctrl #(.MEM_DEPTH(1024), .WAIT_STATES(1)) dut1 (
        .clk(clk),
        .rst_n(rst_n),
        .ext_mem_addr(addr),
        .ext_mem_wdata(wdata),
        .ext_mem_rdata(rdata1),
        .ext_mem_rdata_oe(oe1),
        .ext_mem_read(rd),
        .ext_mem_write(wr),
        .ext_mem_cs(cs1),
        .ext_mem_ready(rdy1),
        .bus_error(berr1)
    );

    ext_mem_ctrl #(.MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk),
        .rst_n(rst_n),
        .ext_mem_addr(addr),
        .ext_mem_wdata(wdata),
        .ext_mem_rdata(rdata0),
        .ext_mem_rdata_oe(oe0),
        .ext_mem_read(rd),
        .ext_mem_write(wr),
        .ext_mem_cs(cs0),
        .ext_mem_ready(rdy0),
        .bus_error(berr0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        rd  = 1'b0;
        wr  = 1'b0;
        cs1 = 1'b0;
        cs0 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = 16'h0000;
        wdata = 8'h00;
        idle_bus();

        dut1.mem[32] <= 8'h11;
        dut1.mem[48] <= 8'h00;
        dut1.mem[64] <= 8'h3C;
        dut1.mem[65] <= 8'hC3;
        dut0.mem[1023] <= 8'h5C;
        dut0.mem[0] <= 8'h12;

        tick();
        tick();
        chk("rst_ready",  32'(rdy1),   32'h0);
        chk("rst_berr",   32'(berr1),  32'h0);
        chk("rst_oe",     32'(oe1),    32'h0);
        chk("rst_rdata1", 32'(rdata1), 32'h00);
        chk("rst_rdata0", 32'(rdata0), 32'h00);
        rst_n = 1'b1;
        tick();

        // WS=1 write 0xA5 to 0x0010
        addr = 16'h0010; wdata = 8'hA5; wr = 1'b1; cs1 = 1'b1;
        tick();
        chk("w1_wait_rdy", 32'(rdy1), 32'h0);
        tick();
        chk("w1_ack_rdy",  32'(rdy1), 32'h1);
        chk("w1_ack_berr", 32'(berr1), 32'h0);
        chk("w1_mem",      32'(dut1.mem[16]), 32'hA5);
        idle_bus();
        tick();
        chk("w1_hold_rdy", 32'(rdy1), 32'h0);
        tick();

        // WS=1 read back 0x0010
        addr = 16'h0010; rd = 1'b1; cs1 = 1'b1;
        tick();
        chk("r1_wait_rdy", 32'(rdy1), 32'h0);
        tick();
        chk("r1_ack_rdy",   32'(rdy1),   32'h1);
        chk("r1_ack_rdata", 32'(rdata1), 32'hA5);
        chk("r1_ack_oe",    32'(oe1),    32'h1);
        chk("r1_ack_berr",  32'(berr1),  32'h0);
        idle_bus();
        #1;
        chk("r1_oe_drop", 32'(oe1), 32'h0);
        tick();
        tick();

        // WS=0 read of last location
        addr = 16'h03FF; rd = 1'b1; cs0 = 1'b1;
        tick();
        chk("r0_ack_rdy",   32'(rdy0),   32'h1);
        chk("r0_ack_rdata", 32'(rdata0), 32'h5C);
        chk("r0_ack_berr",  32'(berr0),  32'h0);
        idle_bus();
        tick();
        chk("r0_hold_rdy", 32'(rdy0), 32'h0);
        tick();

        // WS=0 read just past the end
        addr = 16'h0400; rd = 1'b1; cs0 = 1'b1;
        tick();
        chk("r0oor_rdy",   32'(rdy0),   32'h1);
        chk("r0oor_berr",  32'(berr0),  32'h1);
        chk("r0oor_rdata", 32'(rdata0), 32'hFF);
        idle_bus();
        tick();
        chk("r0oor_berr_off", 32'(berr0), 32'h0);
        tick();

        // WS=0 out-of-range write must not alias onto location 0
        addr = 16'h0400; wdata = 8'h99; wr = 1'b1; cs0 = 1'b1;
        tick();
        chk("w0oor_rdy",   32'(rdy0),   32'h1);
        chk("w0oor_berr",  32'(berr0),  32'h1);
        chk("w0oor_mem0",  32'(dut0.mem[0]), 32'h12);
        chk("w0oor_rdata_hold", 32'(rdata0), 32'hFF);
        idle_bus();
        tick();
        tick();

        // WS=1 read held for 10 cycles
        addr = 16'h0010; rd = 1'b1; cs1 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rdy1) pulses++;
        end
        chk("held_pulses", 32'(pulses), 32'd1);
        chk("held_oe",     32'(oe1),    32'h1);
        idle_bus();
        #1;
        chk("held_oe_drop", 32'(oe1), 32'h0);
        tick();
        tick();

        // WS=1 read and write together at 0x0020
        addr = 16'h0020; wdata = 8'h55; rd = 1'b1; wr = 1'b1; cs1 = 1'b1;
        tick();
        tick();
        chk("rw_rdy",   32'(rdy1),   32'h1);
        chk("rw_berr",  32'(berr1),  32'h1);
        chk("rw_rdata", 32'(rdata1), 32'hFF);
        chk("rw_mem",   32'(dut1.mem[32]), 32'h11);
        idle_bus();
        tick();
        tick();

        // WS=1 write aborted by reset in WAIT
        addr = 16'h0030; wdata = 8'h77; wr = 1'b1; cs1 = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_rdy",   32'(rdy1),   32'h0);
        chk("abort_berr",  32'(berr1),  32'h0);
        chk("abort_oe",    32'(oe1),    32'h0);
        chk("abort_rdata", 32'(rdata1), 32'h00);
        idle_bus();
        tick();
        tick();
        chk("abort_rdy_late", 32'(rdy1), 32'h0);
        chk("abort_mem",      32'(dut1.mem[48]), 32'h00);
        rst_n = 1'b1;
        tick();

        // WS=1 back-to-back reads, strobe low for one cycle between
        addr = 16'h0040; rd = 1'b1; cs1 = 1'b1;
        tick();
        tick();
        chk("b2b_a_rdy",   32'(rdy1),   32'h1);
        chk("b2b_a_rdata", 32'(rdata1), 32'h3C);
        tick();
        chk("b2b_hold_rdy", 32'(rdy1), 32'h0);
        chk("b2b_hold_oe",  32'(oe1),  32'h1);
        rd = 1'b0;
        tick();
        addr = 16'h0041; rd = 1'b1;
        tick();
        chk("b2b_b_wait_rdy", 32'(rdy1), 32'h0);
        tick();
        chk("b2b_b_rdy",   32'(rdy1),   32'h1);
        chk("b2b_b_rdata", 32'(rdata1), 32'hC3);
        idle_bus();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
